// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - register file write-port controller: reset clear sweep, then round-robin arbitration of two writeback requesters
module rf_write_arbiter #(
   parameter int NREG = 32,
   parameter int DW   = 32,
   parameter int AW   = 5
) (
   input  logic          clk,
   input  logic          rstd,
   input  logic          v0,
   input  logic [AW-1:0] a0,
   input  logic [DW-1:0] d0,
   output logic          rdy0,
   input  logic          v1,
   input  logic [AW-1:0] a1,
   input  logic [DW-1:0] d1,
   output logic          rdy1,
   output logic [AW-1:0] wa,
   output logic [DW-1:0] wr,
   output logic          wren,
   output logic          init_done,
   output logic [15:0]   stall_cnt
);

   typedef enum logic {INIT, RUN} state_t;

   state_t        state, state_nxt;
   logic [AW-1:0] cnt, cnt_nxt;
   logic          ptr, ptr_nxt;
   logic [AW-1:0] wa_nxt;
   logic [DW-1:0] wr_nxt;
   logic          wren_nxt;
   logic [15:0]   stall_nxt;
   logic          run, g0, g1;

   // ptr only breaks ties; a lone requester is always served
   assign run       = (state == RUN);
   assign g0        = run & v0 & (~v1 | ~ptr);
   assign g1        = run & v1 & (~v0 | ptr);
   assign rdy0      = g0;
   assign rdy1      = g1;
   assign init_done = run;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      ptr_nxt   = ptr;
      wa_nxt    = wa;
      wr_nxt    = wr;
      wren_nxt  = 1'b1;
      stall_nxt = stall_cnt;
      case (state)
         INIT: begin
            wa_nxt   = cnt;
            wr_nxt   = '0;
            wren_nxt = 1'b0;
            cnt_nxt  = cnt + 1'b1;
            if (cnt == AW'(NREG - 1))
               state_nxt = RUN;
         end
         RUN: begin
            if (g0) begin
               wa_nxt   = a0;
               wr_nxt   = d0;
               wren_nxt = (a0 == '0);
               ptr_nxt  = 1'b1;
            end else if (g1) begin
               wa_nxt   = a1;
               wr_nxt   = d1;
               wren_nxt = (a1 == '0);
               ptr_nxt  = 1'b0;
            end
            if (((v0 & ~g0) | (v1 & ~g1)) && (stall_cnt != 16'hFFFF))
               stall_nxt = stall_cnt + 16'd1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstd) begin
      if (!rstd) begin
         state     <= INIT;
         cnt       <= '0;
         ptr       <= 1'b0;
         wa        <= '0;
         wr        <= '0;
         wren      <= 1'b1;
         stall_cnt <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         ptr       <= ptr_nxt;
         wa        <= wa_nxt;
         wr        <= wr_nxt;
         wren      <= wren_nxt;
         stall_cnt <= stall_nxt;
      end
   end

endmodule
